// File: rtl/mem_handshake_responder_if.sv
`default_nettype none
// ============================================================================
// Module : mem_handshake_responder_if
// Brief  : MOV/MOC four-phase memory handshake bundle between CPU and memory.
// Rev    : 1.0
// ============================================================================
interface mem_handshake_responder_if;
   logic        MOV;
   logic        R_W;
   logic [7:0]  address;
   logic [1:0]  DT;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        MOC;
   logic        err;

   modport master (
      output MOV, R_W, address, DT, data_in,
      input  data_out, MOC, err
   );

   modport slave (
      input  MOV, R_W, address, DT, data_in,
      output data_out, MOC, err
   );
endinterface
`default_nettype wire

// File: rtl/mem_handshake_responder.sv
`default_nettype none
// ============================================================================
// Module : mem_handshake_responder
// Brief  : 256-byte big-endian memory answering MOV with MOC after wait states.
// Rev    : 1.0
// ============================================================================
module mem_handshake_responder #(
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input wire                       clk,
   input wire                       clr,
   mem_handshake_responder_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_WAIT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic [1:0]       C_DT_BYTE   = 2'b00;
   localparam logic [1:0]       C_DT_HALF   = 2'b01;
   localparam logic [1:0]       C_DT_WORD   = 2'b10;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rw_q, rw_d;
   logic [7:0]        addr_q, addr_d;
   logic [1:0]        dt_q, dt_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              moc_q, moc_d;
   logic              err_q, err_d;
   logic [31:0]       dout_q, dout_d;

   logic [7:0]        mem_q [256];

   logic [7:0]        lane_addr [4];
   logic [7:0]        rd_lane   [4];
   logic [7:0]        wr_lane   [4];
   logic [3:0]        lane_en;
   logic [3:0]        mem_we;
   logic              req_bad;
   logic              commit;
   logic [31:0]       rd_data;

   // Lane i is byte address A+i; lane 0 carries the most significant byte.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane_addr[i] = addr_q + 8'(i);
         rd_lane[i]   = mem_q[lane_addr[i]];
      end
   end

   always_comb begin
      req_bad = 1'b1;
      case (dt_q)
         C_DT_BYTE: req_bad = 1'b0;
         C_DT_HALF: req_bad = addr_q[0];
         C_DT_WORD: req_bad = |addr_q[1:0];
         default:   req_bad = 1'b1;
      endcase
   end

   always_comb begin
      rd_data = 32'd0;
      lane_en = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         wr_lane[i] = 8'd0;
      end
      case (dt_q)
         C_DT_BYTE: begin
            rd_data    = {24'd0, rd_lane[0]};
            lane_en    = 4'b0001;
            wr_lane[0] = wdata_q[7:0];
         end
         C_DT_HALF: begin
            rd_data    = {16'd0, rd_lane[0], rd_lane[1]};
            lane_en    = 4'b0011;
            wr_lane[0] = wdata_q[15:8];
            wr_lane[1] = wdata_q[7:0];
         end
         C_DT_WORD: begin
            rd_data    = {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]};
            lane_en    = 4'b1111;
            wr_lane[0] = wdata_q[31:24];
            wr_lane[1] = wdata_q[23:16];
            wr_lane[2] = wdata_q[15:8];
            wr_lane[3] = wdata_q[7:0];
         end
         default: begin
            rd_data = 32'd0;
            lane_en = 4'b0000;
         end
      endcase
   end

   assign commit = (state_q == ST_WAIT) && (cnt_q == '0);
   assign mem_we = (commit && !rw_q && !req_bad) ? lane_en : 4'b0000;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      dt_d    = dt_q;
      wdata_d = wdata_q;
      moc_d   = moc_q;
      err_d   = err_q;
      dout_d  = dout_q;
      case (state_q)
         ST_IDLE: begin
            moc_d = 1'b0;
            if (bus.MOV) begin
               rw_d    = bus.R_W;
               addr_d  = bus.address;
               dt_d    = bus.DT;
               wdata_d = bus.data_in;
               cnt_d   = C_WAIT_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Live bus inputs are ignored here; a MOV drop still completes.
            if (commit) begin
               state_d = ST_ACK;
               moc_d   = 1'b1;
               err_d   = req_bad;
               if (req_bad) begin
                  dout_d = 32'd0;
               end else if (rw_q) begin
                  dout_d = rd_data;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_ACK: begin
            if (!bus.MOV) begin
               moc_d   = 1'b0;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            moc_d   = 1'b0;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= 8'd0;
         dt_q    <= 2'd0;
         wdata_q <= 32'd0;
         moc_q   <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         dt_q    <= dt_d;
         wdata_q <= wdata_d;
         moc_q   <= moc_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   // Array contents survive reset; reset only suppresses a pending commit.
   always_ff @(posedge clk) begin
      if (!clr) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) begin
               mem_q[lane_addr[i]] <= wr_lane[i];
            end
         end
      end
   end

   assign bus.MOC      = moc_q;
   assign bus.err      = err_q;
   assign bus.data_out = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_handshake_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_handshake_responder
// Brief  : Randomized bench with a byte-array reference model, two DUT builds.
// Rev    : 1.0
// ============================================================================
module tb_mem_handshake_responder;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        clr0 = 1'b1;
   logic        mov = 1'b0;
   logic        en0 = 1'b1;
   logic        r_w = 1'b0;
   logic [7:0]  addr = 8'd0;
   logic [1:0]  dt = 2'd0;
   logic [31:0] wdat = 32'd0;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [7:0]  ref_mem [256];
   logic [31:0] ref_dout  = 32'd0;
   logic [31:0] ref_dout0 = 32'd0;

   always #5 clk = ~clk;

   mem_handshake_responder_if bus ();
   mem_handshake_responder_if bus0 ();

   assign bus.MOV      = mov;
   assign bus.R_W      = r_w;
   assign bus.address  = addr;
   assign bus.DT       = dt;
   assign bus.data_in  = wdat;
   assign bus0.MOV     = mov & en0;
   assign bus0.R_W     = r_w;
   assign bus0.address = addr;
   assign bus0.DT      = dt;
   assign bus0.data_in = wdat;

   mem_handshake_responder #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   mem_handshake_responder #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
      .clk (clk),
      .clr (clr0),
      .bus (bus0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected outcome of one request computed from the memory-map rules.
   task automatic model(input logic rw, input logic [7:0] a, input logic [1:0] t,
                        input logic [31:0] wd, input logic use0,
                        output logic [31:0] ed, output logic [31:0] ed0, output logic ee);
      int base;
      int n;
      logic bad;
      base = int'(a);
      n    = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
      bad  = (t == 2'd3) || (t == 2'd1 && (base % 2) != 0) || (t == 2'd2 && (base % 4) != 0);
      ee   = bad;
      if (bad) begin
         ed  = 32'd0;
         ed0 = 32'd0;
      end else if (rw) begin
         ed = 32'd0;
         for (int i = 0; i < n; i++) ed = (ed << 8) | 32'(ref_mem[base + i]);
         ed0 = ed;
      end else begin
         ed  = ref_dout;
         ed0 = ref_dout0;
         for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*(n-1-i) +: 8];
      end
      ref_dout = ed;
      if (use0) ref_dout0 = ed0;
   endtask

   task automatic txn(input logic rw, input logic [7:0] a, input logic [1:0] t,
                      input logic [31:0] wd, input int hold, input logic use0);
      logic [31:0] ed, ed0;
      logic        ee;
      int          lat, lat0;
      model(rw, a, t, wd, use0, ed, ed0, ee);
      @(negedge clk);
      mov = 1'b1; en0 = use0; r_w = rw; addr = a; dt = t; wdat = wd;
      @(posedge clk); #1;
      lat = 0; lat0 = 0;
      for (int n = 1; n <= 20 && (lat == 0 || (use0 && lat0 == 0)); n++) begin
         @(posedge clk); #1;
         if (lat == 0 && bus.MOC) lat = n;
         if (use0 && lat0 == 0 && bus0.MOC) lat0 = n;
      end
      chk("latency", lat, W + 1);
      chk("dout", bus.data_out, ed);
      chk("err", 32'(bus.err), 32'(ee));
      if (use0) begin
         chk("latency0", lat0, 1);
         chk("dout0", bus0.data_out, ed0);
         chk("err0", 32'(bus0.err), 32'(ee));
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_moc", 32'(bus.MOC), 32'd1);
         chk("hold_dout", bus.data_out, ed);
      end
      @(negedge clk);
      mov = 1'b0;
      @(posedge clk); #1;
      chk("moc_fall", 32'(bus.MOC), 32'd0);
      chk("err_fall", 32'(bus.err), 32'd0);
      if (use0) chk("moc_fall0", 32'(bus0.MOC), 32'd0);
   endtask

   initial begin
      int ones, first;
      logic [31:0] old30;

      // Reset held two edges with MOV asserted.
      mov = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_moc", 32'(bus.MOC), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_dout", bus.data_out, 32'd0);
      chk("rst_moc0", 32'(bus0.MOC), 32'd0);
      @(negedge clk);
      mov = 1'b0; clr = 1'b0; clr0 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_moc", 32'(bus.MOC), 32'd0);

      // Fill the whole array so every later read has a known value.
      for (int w = 0; w < 64; w++) txn(1'b0, 8'(w * 4), 2'd2, $urandom, 0, 1'b1);

      txn(1'b0, 8'h10, 2'd2, 32'hDEADBEEF, 0, 1'b1);
      txn(1'b1, 8'h10, 2'd2, 32'd0, 0, 1'b1);
      chk("t2_word", bus.data_out, 32'hDEADBEEF);
      txn(1'b1, 8'h11, 2'd0, 32'd0, 0, 1'b1);
      chk("t2_byte", bus.data_out, 32'h000000AD);

      txn(1'b0, 8'h20, 2'd1, 32'h1234CAFE, 0, 1'b1);
      txn(1'b0, 8'h21, 2'd0, 32'h00000055, 0, 1'b1);
      txn(1'b1, 8'h20, 2'd2, 32'd0, 0, 1'b1);
      chk("t3_hi", 32'(bus.data_out[31:16]), 32'h0000CA55);

      txn(1'b1, 8'h02, 2'd2, 32'd0, 0, 1'b1);
      txn(1'b0, 8'h02, 2'd2, 32'h11111111, 0, 1'b1);
      txn(1'b0, 8'h00, 2'd3, 32'h22222222, 0, 1'b1);
      txn(1'b0, 8'h03, 2'd1, 32'h33333333, 0, 1'b1);
      txn(1'b1, 8'h00, 2'd2, 32'd0, 0, 1'b1);

      txn(1'b0, 8'hFC, 2'd2, 32'hA1B2C3D4, 0, 1'b1);
      txn(1'b1, 8'hFC, 2'd2, 32'd0, 0, 1'b1);
      txn(1'b1, 8'hFE, 2'd1, 32'd0, 0, 1'b1);
      txn(1'b1, 8'hFF, 2'd0, 32'd0, 0, 1'b1);

      txn(1'b1, 8'h40, 2'd2, 32'd0, 5, 1'b1);

      // MOV dropped right after capture: exactly one MOC cycle.
      begin
         logic [31:0] ed, ed0;
         logic ee;
         model(1'b1, 8'h44, 2'd2, 32'd0, 1'b0, ed, ed0, ee);
         @(negedge clk);
         mov = 1'b1; en0 = 1'b0; r_w = 1'b1; addr = 8'h44; dt = 2'd2;
         @(posedge clk);
         @(negedge clk);
         mov = 1'b0;
         ones = 0; first = 0;
         for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (bus.MOC) begin
               ones++;
               if (first == 0) first = n;
               chk("drop_dout", bus.data_out, ed);
            end
         end
         chk("drop_pulses", ones, 1);
         chk("drop_when", first, W + 1);
      end

      // Reset during WAIT of a word write aborts the commit.
      old30 = {ref_mem[8'h30], ref_mem[8'h31], ref_mem[8'h32], ref_mem[8'h33]};
      @(negedge clk);
      mov = 1'b1; en0 = 1'b0; r_w = 1'b0; addr = 8'h30; dt = 2'd2; wdat = ~old30;
      @(posedge clk);
      @(negedge clk);
      mov = 1'b0; clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      ones = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (bus.MOC) ones++;
      end
      chk("abort_moc", ones, 0);
      chk("abort_dout", bus.data_out, 32'd0);
      ref_dout = 32'd0;
      txn(1'b1, 8'h30, 2'd2, 32'd0, 0, 1'b1);
      chk("abort_old", bus.data_out, old30);

      for (int k = 0; k < 150; k++) begin
         txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
             $urandom, $urandom_range(0, 2), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
